// File: rtl/rep_str_seq.sv
// rep_str_seq: multi-cycle sequencer for x86 string instructions (MOVS, STOS, LODS, +REP).
// Issues memory read/write requests, steps ESI/EDI by the operand size in the direction
// given by DF, decrements ECX under REP, and pulses done with the final register values.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, op, rep, size, DF_in   operation request (sampled when ready=1)
//   esi_in/edi_in/ecx_in/eax_in   architectural register values, sampled on start
//   abort                         synchronous flush back to IDLE, no done
//   ready                         high in IDLE only
//   rd_req/rd_addr/rd_size        read request, held until rd_ack
//   rd_ack/rd_data                read completion and data
//   wr_req/wr_addr/wr_size/wr_data  write request, held until wr_ack
//   wr_ack                        write accepted
//   esi_out/edi_out/ecx_out/eax_out  working and final register values
//   done                          one-cycle completion pulse
module rep_str_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        rep,
  input  logic [1:0]  size,
  input  logic        DF_in,
  input  logic [31:0] esi_in,
  input  logic [31:0] edi_in,
  input  logic [31:0] ecx_in,
  input  logic [31:0] eax_in,
  input  logic        abort,
  output logic        ready,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  output logic [1:0]  rd_size,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [1:0]  wr_size,
  output logic [31:0] wr_data,
  input  logic        wr_ack,
  output logic [31:0] esi_out,
  output logic [31:0] edi_out,
  output logic [31:0] ecx_out,
  output logic [31:0] eax_out,
  output logic        done
);

  localparam logic [1:0] OpMovs = 2'b00;
  localparam logic [1:0] OpStos = 2'b01;
  localparam logic [1:0] OpLods = 2'b10;
  localparam logic [1:0] OpRsvd = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StRead,
    StWrite,
    StUpdate,
    StDone
  } state_e;

  state_e      state_q;
  logic [1:0]  op_q;
  logic        rep_q;
  logic [1:0]  size_q;
  logic        df_q;
  logic [31:0] esi_q, edi_q, ecx_q, eax_q;
  logic [31:0] buf_q;
  logic        rd_req_q, wr_req_q, done_q;

  logic [31:0] mask;
  logic [31:0] delta;
  logic [31:0] esi_nxt, edi_nxt, ecx_dec;

  always_comb begin
    mask  = 32'hFFFF_FFFF;
    delta = 32'd4;
    unique case (size_q)
      2'b00: begin
        mask  = 32'h0000_00FF;
        delta = 32'd1;
      end
      2'b01: begin
        mask  = 32'h0000_FFFF;
        delta = 32'd2;
      end
      default: ;
    endcase
  end

  // Modulo-2^32 pointer stepping; wrap through zero is intentional.
  assign esi_nxt = df_q ? esi_q - delta : esi_q + delta;
  assign edi_nxt = df_q ? edi_q - delta : edi_q + delta;
  assign ecx_dec = ecx_q - 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= 2'b00;
      rep_q    <= 1'b0;
      size_q   <= 2'b00;
      df_q     <= 1'b0;
      esi_q    <= '0;
      edi_q    <= '0;
      ecx_q    <= '0;
      eax_q    <= '0;
      buf_q    <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // Any in-flight transfer is dropped; working registers keep their last values.
        state_q  <= StIdle;
        rd_req_q <= 1'b0;
        wr_req_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              op_q    <= op;
              rep_q   <= rep;
              size_q  <= size;
              df_q    <= DF_in;
              esi_q   <= esi_in;
              edi_q   <= edi_in;
              ecx_q   <= ecx_in;
              eax_q   <= eax_in;
              state_q <= StCheck;
            end
          end
          StCheck: begin
            if ((rep_q && ecx_q == 32'd0) || op_q == OpRsvd) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else if (op_q == OpStos) begin
              state_q  <= StWrite;
              wr_req_q <= 1'b1;
            end else begin
              state_q  <= StRead;
              rd_req_q <= 1'b1;
            end
          end
          StRead: begin
            if (rd_ack) begin
              rd_req_q <= 1'b0;
              buf_q    <= rd_data & mask;
              if (op_q == OpLods) begin
                // Only the low size bytes of EAX are replaced.
                eax_q   <= (eax_q & ~mask) | (rd_data & mask);
                state_q <= StUpdate;
              end else begin
                state_q  <= StWrite;
                wr_req_q <= 1'b1;
              end
            end
          end
          StWrite: begin
            if (wr_ack) begin
              wr_req_q <= 1'b0;
              state_q  <= StUpdate;
            end
          end
          StUpdate: begin
            if (op_q != OpStos) esi_q <= esi_nxt;
            if (op_q != OpLods) edi_q <= edi_nxt;
            if (rep_q) ecx_q <= ecx_dec;
            if (rep_q && ecx_dec != 32'd0) begin
              if (op_q == OpStos) begin
                state_q  <= StWrite;
                wr_req_q <= 1'b1;
              end else begin
                state_q  <= StRead;
                rd_req_q <= 1'b1;
              end
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign ready   = (state_q == StIdle);
  assign rd_req  = rd_req_q;
  assign rd_addr = esi_q;
  assign rd_size = size_q;
  assign wr_req  = wr_req_q;
  assign wr_addr = edi_q;
  assign wr_size = size_q;
  assign wr_data = ((op_q == OpStos) ? eax_q : buf_q) & mask;
  assign esi_out = esi_q;
  assign edi_out = edi_q;
  assign ecx_out = ecx_q;
  assign eax_out = eax_q;
  assign done    = done_q;

  // OpMovs is implied by the other decodes; reference it so the name documents the encoding.
  logic unused_op_movs;
  assign unused_op_movs = (op_q == OpMovs);

endmodule
